// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared constants and types for the writeback controller
package reg_wb_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int REG_NUM = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LD
  } wb_sel_e;

endpackage

// File: rtl/wb_load_fifo.sv
// rtl/wb_load_fifo.sv - synchronous load-return FIFO with full/empty/count
module wb_load_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Callers guard push with !full and pop with !empty; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - writeback arbiter, load FIFO and busy scoreboard
// Optional forwarding outputs are built when REG_WB_FWD_EN is defined.
module reg_wb_ctrl #(
  parameter int DATA_W   = reg_wb_pkg::DATA_W,
  parameter int ADDR_W   = reg_wb_pkg::ADDR_W,
  parameter int LD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic              iss_long,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  output logic              hazard_a,
  output logic              hazard_b,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
`ifdef REG_WB_FWD_EN
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              reg_w_en,
  output logic [ADDR_W-1:0] reg_wa_c,
  output logic [DATA_W-1:0] reg_wd_c
);

  import reg_wb_pkg::*;

  localparam int NREG  = 1 << ADDR_W;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(LD_DEPTH) + 1;

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              ld_full;
  logic              ld_empty;
  logic [CNT_W-1:0]  ld_count;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              ld_push;
  logic              ld_pop;
  wb_sel_e           sel;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  wb_load_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ld_push),
    .push_data ({ld_rd, ld_data}),
    .pop       (ld_pop),
    .pop_data  (head),
    .full      (ld_full),
    .empty     (ld_empty),
    .count     (ld_count)
  );

  assign {head_rd, head_data} = head;
  assign ld_ready  = !ld_full;
  assign ld_push   = ld_valid && !ld_full;
  assign alu_ready = !ld_full;
  assign iss_ready = !((iss_rd != '0) && busy[iss_rd]);

  // A full FIFO must drain first, otherwise the ALU has priority over loads.
  always_comb begin
    sel = WB_NONE;
    if (ld_full && !ld_empty) begin
      sel = WB_LD;
    end else if (alu_valid) begin
      sel = WB_ALU;
    end else if (ld_count != '0) begin
      sel = WB_LD;
    end
  end

  assign ld_pop   = (sel == WB_LD);
  assign win_rd   = (sel == WB_LD) ? head_rd   : alu_rd;
  assign win_data = (sel == WB_LD) ? head_data : alu_data;

  // Clear first so a same-cycle reissue to that rd keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (ld_pop && (head_rd != '0)) begin
      busy_nxt[head_rd] = 1'b0;
    end
    if (iss_valid && iss_ready && iss_long && (iss_rd != '0)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_w_en <= 1'b0;
      reg_wa_c <= '0;
      reg_wd_c <= '0;
    end else begin
      reg_w_en <= (sel != WB_NONE) && (win_rd != '0);
      if (sel != WB_NONE) begin
        reg_wa_c <= win_rd;
        reg_wd_c <= win_data;
      end
    end
  end

`ifdef REG_WB_FWD_EN
  assign fwd_a_hit = reg_w_en && (reg_wa_c == rs_a) && (rs_a != '0);
  assign fwd_b_hit = reg_w_en && (reg_wa_c == rs_b) && (rs_b != '0);
  assign fwd_data  = reg_wd_c;
  assign hazard_a  = (rs_a != '0) && busy[rs_a] && !fwd_a_hit;
  assign hazard_b  = (rs_b != '0) && busy[rs_b] && !fwd_b_hit;
`else
  assign hazard_a  = (rs_a != '0) && busy[rs_a];
  assign hazard_b  = (rs_b != '0) && busy[rs_b];
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb/tb_reg_wb_ctrl.sv - directed and randomized checks of reg_wb_ctrl against a queue model
`timescale 1ns/1ps
module tb_reg_wb_ctrl;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int LD_DEPTH = 4;
  localparam int NREG     = 1 << ADDR_W;

  logic              clk = 1'b1;
  logic              rst = 1'b1;
  logic              iss_valid = 1'b0;
  logic              iss_long = 1'b0;
  logic [ADDR_W-1:0] iss_rd = '0;
  logic              iss_ready;
  logic [ADDR_W-1:0] rs_a = '0;
  logic [ADDR_W-1:0] rs_b = '0;
  logic              hazard_a;
  logic              hazard_b;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              alu_ready;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_rd = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_ready;
  logic              reg_w_en;
  logic [ADDR_W-1:0] reg_wa_c;
  logic [DATA_W-1:0] reg_wd_c;
`ifdef REG_WB_FWD_EN
  logic              fwd_a_hit;
  logic              fwd_b_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  reg_wb_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LD_DEPTH (LD_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .rs_a      (rs_a),
    .rs_b      (rs_b),
    .hazard_a  (hazard_a),
    .hazard_b  (hazard_b),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
`ifdef REG_WB_FWD_EN
    .fwd_a_hit (fwd_a_hit),
    .fwd_b_hit (fwd_b_hit),
    .fwd_data  (fwd_data),
`endif
    .reg_w_en  (reg_w_en),
    .reg_wa_c  (reg_wa_c),
    .reg_wd_c  (reg_wd_c)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  ent_t              nq[$];
  bit                busy_m[NREG];
  bit                nbusy[NREG];
  bit                m_en = 0;
  bit                n_en = 0;
  logic [ADDR_W-1:0] m_wa = '0;
  logic [ADDR_W-1:0] n_wa = '0;
  logic [DATA_W-1:0] m_wd = '0;
  logic [DATA_W-1:0] n_wd = '0;
  bit                m_ok = 0;
  bit                n_ok = 0;

  function automatic bit fwd_hit(logic [ADDR_W-1:0] rs);
    return m_en && (m_wa == rs) && (rs != '0);
  endfunction

  function automatic bit exp_haz(logic [ADDR_W-1:0] rs);
    bit h;
    h = (rs != '0) && busy_m[rs];
`ifdef REG_WB_FWD_EN
    if (fwd_hit(rs)) h = 0;
`endif
    return h;
  endfunction

  // Compare against the model, then work out the model state for the next edge.
  always @(negedge clk) begin
    bit   full;
    ent_t w;
    full = (q.size() == LD_DEPTH);
    if (m_ok) begin
      chk("ld_ready", ld_ready, !full);
      chk("alu_ready", alu_ready, !full);
      chk("iss_ready", iss_ready, !((iss_rd != '0) && busy_m[iss_rd]));
      chk("hazard_a", hazard_a, exp_haz(rs_a));
      chk("hazard_b", hazard_b, exp_haz(rs_b));
      chk("reg_w_en", reg_w_en, m_en);
      if (m_en) begin
        chk("reg_wa_c", reg_wa_c, m_wa);
        chk("reg_wd_c", reg_wd_c, m_wd);
      end
`ifdef REG_WB_FWD_EN
      chk("fwd_a_hit", fwd_a_hit, fwd_hit(rs_a));
      chk("fwd_b_hit", fwd_b_hit, fwd_hit(rs_b));
      if (m_en) chk("fwd_data", fwd_data, m_wd);
`endif
    end
    nq    = q;
    nbusy = busy_m;
    n_wa  = m_wa;
    n_wd  = m_wd;
    n_en  = 0;
    if (rst) begin
      nq.delete();
      foreach (nbusy[i]) nbusy[i] = 0;
      n_wa = '0;
      n_wd = '0;
    end else begin
      if (full || (!alu_valid && q.size() > 0)) begin
        w    = nq.pop_front();
        n_en = (w.rd != '0);
        n_wa = w.rd;
        n_wd = w.data;
        if (w.rd != '0) nbusy[w.rd] = 0;
      end else if (alu_valid) begin
        n_en = (alu_rd != '0);
        n_wa = alu_rd;
        n_wd = alu_data;
      end
      if (ld_valid && !full) begin
        w.rd   = ld_rd;
        w.data = ld_data;
        nq.push_back(w);
      end
      if (iss_valid && iss_long && (iss_rd != '0) && !busy_m[iss_rd]) nbusy[iss_rd] = 1;
    end
    n_ok = 1;
  end

  always @(posedge clk) begin
    if (n_ok) begin
      q      = nq;
      busy_m = nbusy;
      m_en   = n_en;
      m_wa   = n_wa;
      m_wd   = n_wd;
      m_ok   = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iss_valid = 1'b0;
    iss_long  = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    // Reset with loads queued and a busy destination
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9;
    ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'h1234;
    cyc();
    iss_valid = 1'b0; ld_rd = 5'd12; cyc();
    ld_rd = 5'd13; cyc();
    ld_valid = 1'b0; rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_w_en", reg_w_en, 0);
    chk("rst_ld_ready", ld_ready, 1);
    for (int i = 0; i < NREG; i++) begin
      rs_a = 5'(i);
      #2;
      chk("rst_hazard_a", hazard_a, 0);
      cyc();
    end

    // Load to rd=5 and its return three cycles later
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd5; rs_a = 5'd5;
    cyc();
    iss_valid = 1'b0;
    repeat (2) begin
      #2 chk("ld5_hazard_wait", hazard_a, 1);
      cyc();
    end
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEADBEEF;
    #2 chk("ld5_hazard_ret", hazard_a, 1);
    cyc();
    ld_valid = 1'b0;
    chk("ld5_hazard_pop", hazard_a, 1);
    chk("ld5_no_write_yet", reg_w_en, 0);
    cyc();
    chk("ld5_w_en", reg_w_en, 1);
    chk("ld5_wa", reg_wa_c, 5);
    chk("ld5_wd", reg_wd_c, 32'hDEADBEEF);
    chk("ld5_hazard_clr", hazard_a, 0);

    // ALU streaming while four loads fill the FIFO
    alu_valid = 1'b1; alu_rd = 5'd3; ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_rd = 5'(7 + i); ld_data = 32'h100 + 32'(i); alu_data = 32'(i);
      cyc();
      chk("cont_alu_wa", reg_wa_c, 3);
      chk("cont_alu_wd", reg_wd_c, i);
    end
    ld_valid = 1'b0;
    chk("cont_alu_stall", alu_ready, 0);
    chk("cont_ld_full", ld_ready, 0);
    cyc();
    chk("cont_ld7_wa", reg_wa_c, 7);
    chk("cont_ld7_wd", reg_wd_c, 32'h100);
    chk("cont_alu_resume", alu_ready, 1);
    cyc();
    chk("cont_alu_again", reg_wa_c, 3);
    alu_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("cont_drain_wa", reg_wa_c, 7 + i);
      chk("cont_drain_wd", reg_wd_c, 32'h100 + i);
    end

    // WAW stall on rd=6
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd6;
    cyc();
    iss_long = 1'b0;
    repeat (2) begin
      #2 chk("waw_stall", iss_ready, 0);
      cyc();
    end
    ld_valid = 1'b1; ld_rd = 5'd6; ld_data = $urandom;
    cyc();
    ld_valid = 1'b0;
    chk("waw_stall_pop", iss_ready, 0);
    cyc();
    chk("waw_release", iss_ready, 1);
    iss_valid = 1'b0;

    // rd=0 results are consumed without writes or busy bits
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h2;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd0; rs_a = 5'd0;
    cyc();
    idle_in();
    chk("rd0_alu", reg_w_en, 0);
    cyc();
    chk("rd0_ld", reg_w_en, 0);
    cyc();
    chk("rd0_idle", reg_w_en, 0);
    chk("rd0_hazard", hazard_a, 0);
    chk("rd0_iss_ready", iss_ready, 1);
    // FIFO back at zero: exactly four more pushes fill it
    alu_valid = 1'b1; alu_rd = 5'd1; ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_rd = 5'(20 + i); ld_data = $urandom;
      chk("rd0_room", ld_ready, 1);
      cyc();
    end
    idle_in();
    chk("rd0_full_after4", ld_ready, 0);
    repeat (6) cyc();

`ifdef REG_WB_FWD_EN
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd12;
    cyc();
    idle_in();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hABC;
    cyc();
    alu_valid = 1'b0; rs_b = 5'd12;
    #1;
    chk("fwd_b_hit_lit", fwd_b_hit, 1);
    chk("fwd_data_lit", fwd_data, 32'hABC);
    chk("fwd_hazard_b_lit", hazard_b, 0);
    cyc();
    chk("fwd_hazard_b_after", hazard_b, 1);
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h55;
    cyc();
    ld_valid = 1'b0;
    repeat (2) cyc();
`endif

    // Randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      iss_valid = 1'($urandom_range(0, 1));
      iss_long  = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      rs_a      = 5'($urandom_range(0, 7));
      rs_b      = 5'($urandom_range(0, 7));
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = 1'($urandom_range(0, 1));
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      cyc();
    end
    idle_in();
    rst = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
